serial_adder: RTL

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first. Each chunk goes through one CHUNK-bit ripple adder built from the full-adder cell, and a registered carry links the chunks. Operands come in on a valid/ready handshake. The result and flags go out on a second valid/ready handshake. The block is the datapath adder for the small-area CPU configuration, where one shared narrow ripple stage replaces a full-width adder.

---
 rtl/serial_adder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed CHUNK bits per clock,
// LSB chunk first, through one narrow ripple stage with a registered inter-chunk carry.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_cout;
    logic              chunk_cmsb;
    logic [WIDTH-1:0]  sum_full;
    logic              last_chunk;

    // CHUNK full-adder cells in a ripple chain; chunk_cmsb is the carry into the top cell,
    // which on the final chunk is the carry into bit WIDTH-1.
    always_comb begin : ripple
        logic c;
        c          = carry_q;
        chunk_sum  = '0;
        chunk_cmsb = 1'b0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                chunk_cmsb = c;
            end
            chunk_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ c;
            c            = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
        end
        chunk_cout = c;
    end

    // New chunk enters at the MSB end so the LSB chunk ends up at the bottom after N shifts.
    assign sum_full   = (sum_sh_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
    assign last_chunk = (cnt_q == CntW'(N - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> CHUNK;
                b_sh_d   = b_sh_q >> CHUNK;
                sum_sh_d = sum_full;
                carry_d  = chunk_cout;
                if (last_chunk) begin
                    result_d    = sum_full;
                    carry_out_d = chunk_cout;
                    overflow_d  = chunk_cmsb ^ chunk_cout;
                    zero_d      = (sum_full == '0);
                    cnt_d       = '0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule
